// File: rtl/rice_encoder.sv
// rice_encoder: streaming Rice/Golomb encoder packing codes MSB-first into W_WORD-bit words.
// Define RICE_ENC_ESCAPE_EN to enable escape coding for quotients >= Q_ESC.
module rice_encoder #(
  parameter int W_IN   = 16,
  parameter int W_WORD = 32,
  parameter int Q_ESC  = 16,
  parameter int K_W    = $clog2(W_IN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W_IN-1:0]             in_data,
  input  logic [K_W-1:0]              in_k,
  input  logic                        flush_req,
  output logic                        flush_ack,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [W_WORD-1:0]           out_data,
  output logic [$clog2(W_WORD+1)-1:0] out_nbits,
  output logic                        out_last
);

  localparam int NB_W = $clog2(W_WORD + 1);
`ifdef RICE_ENC_ESCAPE_EN
  localparam bit ESC_EN = 1'b1;
  localparam int PRE_W  = NB_W;
`else
  localparam bit ESC_EN = 1'b0;
  localparam int PRE_W  = W_IN;
`endif
  localparam logic [NB_W-1:0] WORD_BITS = NB_W'(W_WORD);

  typedef enum logic [1:0] {IDLE, PREFIX, SUFFIX, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [W_WORD-1:0] acc, acc_nxt;
  logic [NB_W-1:0]   fill, fill_nxt;
  logic [PRE_W-1:0]  pre_cnt, pre_nxt;
  logic [W_IN-1:0]   suf_bits, suf_bits_nxt;
  logic [NB_W-1:0]   suf_len, suf_len_nxt;
  logic [W_WORD-1:0] out_data_nxt;
  logic [NB_W-1:0]   out_nbits_nxt;
  logic              out_valid_nxt, out_last_nxt, flush_ack_nxt;

  logic [K_W-1:0]    k_eff;
  logic [W_IN-1:0]   q, r;
  logic              esc;
  logic              out_free, do_append;
  logic [NB_W-1:0]   free, chunk, new_fill;
  logic [W_WORD-1:0] app_val, merged;

  // The k port can only exceed W_IN-1 when W_IN is not a power of two.
  if ((1 << K_W) > W_IN) begin : g_clamp
    assign k_eff = (in_k > K_W'(W_IN - 1)) ? K_W'(W_IN - 1) : in_k;
  end else begin : g_noclamp
    assign k_eff = in_k;
  end

  assign q   = in_data >> k_eff;
  assign r   = in_data & ~({W_IN{1'b1}} << k_eff);
  assign esc = ESC_EN && (32'(q) >= Q_ESC);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    fill_nxt      = fill;
    pre_nxt       = pre_cnt;
    suf_bits_nxt  = suf_bits;
    suf_len_nxt   = suf_len;
    out_free      = !out_valid || out_ready;
    out_valid_nxt = out_valid && !out_ready;
    out_data_nxt  = out_data;
    out_nbits_nxt = out_nbits;
    out_last_nxt  = out_last;
    flush_ack_nxt = 1'b0;
    free          = WORD_BITS - fill;
    chunk         = '0;
    app_val       = '0;
    do_append     = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (esc) begin
            pre_nxt      = PRE_W'(Q_ESC);
            suf_bits_nxt = in_data;
            suf_len_nxt  = NB_W'(W_IN);
          end else begin
            pre_nxt      = PRE_W'(q);
            suf_bits_nxt = r;
            suf_len_nxt  = NB_W'(k_eff) + NB_W'(1);
          end
          state_nxt = (pre_nxt == '0) ? SUFFIX : PREFIX;
        end else if (flush_req && in_ready && out_free) begin
          flush_ack_nxt = 1'b1;
          state_nxt     = FLUSH;
        end
      end
      PREFIX: begin
        chunk     = (32'(pre_cnt) >= 32'(free)) ? free : NB_W'(pre_cnt);
        app_val   = {W_WORD{1'b1}} >> (WORD_BITS - chunk);
        do_append = out_free || ((fill + chunk) != WORD_BITS);
        if (do_append) begin
          pre_nxt = pre_cnt - PRE_W'(chunk);
          if (pre_nxt == '0) state_nxt = SUFFIX;
        end
      end
      SUFFIX: begin
        // Remaining suffix bits sit right-justified; take the top chunk of them.
        chunk     = (suf_len >= free) ? free : suf_len;
        app_val   = (W_WORD'(suf_bits) >> (suf_len - chunk)) &
                    ({W_WORD{1'b1}} >> (WORD_BITS - chunk));
        do_append = out_free || ((fill + chunk) != WORD_BITS);
        if (do_append) begin
          suf_len_nxt = suf_len - chunk;
          if (suf_len_nxt == '0) state_nxt = IDLE;
        end
      end
      FLUSH: begin
        out_data_nxt  = acc;
        out_nbits_nxt = fill;
        out_last_nxt  = 1'b1;
        out_valid_nxt = 1'b1;
        acc_nxt       = '0;
        fill_nxt      = '0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    new_fill = fill + chunk;
    merged   = acc | (app_val << (free - chunk));
    if (do_append) begin
      if (new_fill == WORD_BITS) begin
        out_data_nxt  = merged;
        out_nbits_nxt = WORD_BITS;
        out_last_nxt  = 1'b0;
        out_valid_nxt = 1'b1;
        acc_nxt       = '0;
        fill_nxt      = '0;
      end else begin
        acc_nxt  = merged;
        fill_nxt = new_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      fill      <= '0;
      pre_cnt   <= '0;
      suf_bits  <= '0;
      suf_len   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
      flush_ack <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      fill      <= fill_nxt;
      pre_cnt   <= pre_nxt;
      suf_bits  <= suf_bits_nxt;
      suf_len   <= suf_len_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_nbits <= out_nbits_nxt;
      out_last  <= out_last_nxt;
      flush_ack <= flush_ack_nxt;
      in_ready  <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_rice_encoder.sv
// tb_rice_encoder: directed bench for rice_encoder with a bit-queue reference model.
// Expected words come from the model; literal words from hand-worked examples pin the model.
module tb_rice_encoder;

  localparam int Q_ESC = 16;
`ifdef RICE_ENC_ESCAPE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_k = '0;
  logic        flush_req = 1'b0;
  logic        flush_ack;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_nbits;
  logic        out_last;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  nbits;
    logic        last;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  bit    bitq[$];

  logic [15:0] mix_d [6] = '{16'd3, 16'd100, 16'd1234, 16'hABCD, 16'd40, 16'd17};
  logic [3:0]  mix_k [6] = '{4'd0, 4'd3, 4'd7, 4'd15, 4'd1, 4'd0};

  rice_encoder #(.W_IN(16), .W_WORD(32), .Q_ESC(Q_ESC), .K_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .flush_req (flush_req),
    .flush_ack (flush_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  // Reference model: serialise each code into a bit queue and cut 32-bit words from it.
  task automatic modelEmit(input int n, input bit last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[31-i] = bitq.pop_front();
    w.nbits = 6'(n);
    w.last  = last;
    exp_q.push_back(w);
  endtask

  task automatic modelSample(input logic [15:0] d, input logic [3:0] k);
    int kk;
    int q;
    kk = int'(k);
    q  = int'(d) >> kk;
    if (ESC && q >= Q_ESC) begin
      repeat (Q_ESC) bitq.push_back(1'b1);
      for (int i = 15; i >= 0; i--) bitq.push_back(d[i]);
    end else begin
      repeat (q) bitq.push_back(1'b1);
      bitq.push_back(1'b0);
      for (int i = kk - 1; i >= 0; i--) bitq.push_back(d[i]);
    end
    while (bitq.size() >= 32) modelEmit(32, 1'b0);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] k);
    int n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      reportTimeout("in_ready_wait");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    modelSample(d, k);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic doFlush();
    int n = 0;
    flush_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!flush_ack && n < 5000);
    flush_req = 1'b0;
    if (!flush_ack) begin
      reportTimeout("flush_ack_wait");
      return;
    end
    modelEmit(bitq.size(), 1'b1);
    @(negedge clk);
    checkOutput("flush_ack_pulse", 64'(flush_ack), 64'd0);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) reportTimeout("drain_wait");
    @(negedge clk);
  endtask

  task automatic checkWord(input string name, input int idx, input logic [31:0] d,
                           input logic [5:0] nb, input logic l);
    if (idx < 0 || idx >= got_q.size()) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got no word, expected 0x%0h/%0d/%0d", name, d, nb, l);
    end else begin
      checkOutput(name, {got_q[idx].data, got_q[idx].nbits, got_q[idx].last}, {d, nb, l});
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_data"},  64'(out_data),  64'd0);
    checkOutput({tag, "_out_nbits"}, 64'(out_nbits), 64'd0);
    checkOutput({tag, "_out_last"},  64'(out_last),  64'd0);
    checkOutput({tag, "_flush_ack"}, 64'(flush_ack), 64'd0);
    checkOutput({tag, "_in_ready"},  64'(in_ready),  64'd0);
  endtask

  // Compare process: every handshaked word against the model, held words for stability.
  word_t held;
  bit    hold_v = 1'b0;
  always @(negedge clk) begin
    word_t w;
    word_t e;
    #1;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        checkOutput("hold_stable", {out_valid, out_data, out_nbits, out_last},
                    {1'b1, held.data, held.nbits, held.last});
      if (out_valid && out_ready) begin
        w.data  = out_data;
        w.nbits = out_nbits;
        w.last  = out_last;
        got_q.push_back(w);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_word: got 0x%0h/%0d/%0d, expected none", w.data, w.nbits, w.last);
        end else begin
          e = exp_q.pop_front();
          checkOutput("word", {w.data, w.nbits, w.last}, {e.data, e.nbits, e.last});
        end
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v      = 1'b1;
        held.data   = out_data;
        held.nbits  = out_nbits;
        held.last   = out_last;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    checkOutput("in_ready_first_clock", 64'(in_ready), 64'd1);

    // 5,k=1 -> 1101
    base = got_q.size();
    applyStimulus(16'd5, 4'd1);
    doFlush();
    waitDrain();
    checkWord("pin_5_k1", base, 32'hD000_0000, 6'd4, 1'b1);

    base = got_q.size();
    repeat (8) applyStimulus(16'd0, 4'd0);
    doFlush();
    waitDrain();
    checkWord("pin_eight_zeros", base, 32'h0000_0000, 6'd8, 1'b1);

    base = got_q.size();
    applyStimulus(16'hFFFF, 4'd0);
    doFlush();
    waitDrain();
    checkWord("pin_ffff_first", base, 32'hFFFF_FFFF, 6'd32, 1'b0);
    checkWord("pin_ffff_flush", got_q.size() - 1, 32'h0, 6'd0, 1'b1);
    checkOutput("ffff_word_count", 64'(got_q.size() - base), ESC ? 64'd2 : 64'd2049);

    base = got_q.size();
    applyStimulus(16'h00FF, 4'd4);
    applyStimulus(16'h00FF, 4'd4);
    doFlush();
    waitDrain();
    checkWord("pin_00ff_w0", base,     32'hFFFE_FFFF, 6'd32, 1'b0);
    checkWord("pin_00ff_w1", base + 1, 32'hEF00_0000, 6'd8,  1'b1);

    // Same pair with the first word held for 20 cycles and a flush pending meanwhile.
    base = got_q.size();
    applyStimulus(16'h00FF, 4'd4);
    applyStimulus(16'h00FF, 4'd4);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) reportTimeout("hold_word_wait");
    out_ready = 1'b0;
    flush_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("hold_no_flush_ack", 64'(flush_ack), 64'd0);
    end
    out_ready = 1'b1;
    doFlush();
    waitDrain();
    checkWord("pin_hold_w0", base,     32'hFFFE_FFFF, 6'd32, 1'b0);
    checkWord("pin_hold_w1", base + 1, 32'hEF00_0000, 6'd8,  1'b1);

    // Output held while a symbol still needs the output register: encoder must stall.
    out_ready = 1'b0;
    applyStimulus(16'h00FF, 4'd0);
`ifdef RICE_ENC_ESCAPE_EN
    applyStimulus(16'h00FF, 4'd0);
`endif
    repeat (20) begin
      @(negedge clk);
      checkOutput("stall_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    doFlush();
    waitDrain();

    for (int i = 0; i < 6; i++) applyStimulus(mix_d[i], mix_k[i]);
    doFlush();
    waitDrain();

    // Reset while the prefix of a long code is in progress.
    applyStimulus(16'h00FF, 4'd0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    bitq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = got_q.size();
    applyStimulus(16'd1, 4'd0);
    doFlush();
    waitDrain();
    checkWord("pin_after_reset", base, 32'h8000_0000, 6'd2, 1'b1);
    checkOutput("after_reset_word_count", 64'(got_q.size() - base), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
